// File: rtl/fifo_ram_ctrl_if.sv
// Push/pop handshake and status bundle between a FIFO requester and fifo_ram_ctrl.
// Optional almost_full/almost_empty members exist only when FIFO_RAM_CTRL_ALMOST_EN is defined.
interface fifo_ram_ctrl_if #(
  parameter int N = 8
);
  logic         wr_en;
  logic [N-1:0] wr_data;
  logic         wr_ready;
  logic         rd_en;
  logic         rd_ready;
  logic [N-1:0] rd_data;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic [3:0]   count;
  logic         busy;
`ifdef FIFO_RAM_CTRL_ALMOST_EN
  logic         almost_full;
  logic         almost_empty;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, rd_ready, rd_data, rd_valid, full, empty, count, busy,
    input  almost_full, almost_empty
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, rd_ready, rd_data, rd_valid, full, empty, count, busy,
    output almost_full, almost_empty
  );
`else
  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, rd_ready, rd_data, rd_valid, full, empty, count, busy
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, rd_ready, rd_data, rd_valid, full, empty, count, busy
  );
`endif
endinterface

// File: rtl/fifo_ram_ctrl.sv
// 8-deep FIFO built on an external 8-word bidirectional-bus RAM; owns the ram_io turnaround.
// Define FIFO_RAM_CTRL_ALMOST_EN to add registered almost_full/almost_empty outputs.
module fifo_ram_ctrl #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  fifo_ram_ctrl_if.slave      bus,
  inout  wire  [N-1:0]        ram_io,
  output logic [2:0]          ram_addr,
  output logic                ram_cs,
  output logic                ram_rw
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_END,
    RD,
    RD_CAP
  } state_t;

  state_t       state, state_n;
  logic [2:0]   wptr, wptr_n;
  logic [2:0]   rptr, rptr_n;
  logic [3:0]   count, count_n;
  logic [N-1:0] wdata_q, wdata_n;
  logic [N-1:0] rd_data_q, rd_data_n;
  logic         rd_valid_q, rd_valid_n;
  logic [2:0]   addr_n;
  logic         cs_n, rw_n;
  logic         io_oe, io_oe_n;
  logic         is_idle, is_empty, is_full;
  logic         push_ok, pop_ok;

  assign is_idle  = (state == IDLE);
  assign is_empty = (count == 4'd0);
  assign is_full  = (count == 4'd8);

  // A pending pop blocks the push so the two never compete for the RAM bus
  assign bus.rd_ready = is_idle && !is_empty;
  assign bus.wr_ready = is_idle && !is_full && !(bus.rd_en && !is_empty);
  assign pop_ok       = bus.rd_ready && bus.rd_en;
  assign push_ok      = bus.wr_ready && bus.wr_en;

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.count    = count;
  assign bus.busy     = !is_idle;

  assign ram_io = io_oe ? wdata_q : {N{1'bz}};

  always_comb begin
    state_n    = state;
    wptr_n     = wptr;
    rptr_n     = rptr;
    count_n    = count;
    wdata_n    = wdata_q;
    rd_data_n  = rd_data_q;
    rd_valid_n = 1'b0;
    addr_n     = ram_addr;
    cs_n       = ram_cs;
    rw_n       = ram_rw;
    io_oe_n    = io_oe;
    unique case (state)
      IDLE: begin
        if (pop_ok) begin
          state_n = RD;
          addr_n  = rptr;
          cs_n    = 1'b1;
          rw_n    = 1'b0;
          io_oe_n = 1'b0;
        end else if (push_ok) begin
          state_n = WR;
          wdata_n = bus.wr_data;
          addr_n  = wptr;
          cs_n    = 1'b1;
          rw_n    = 1'b1;
          io_oe_n = 1'b1;
        end
      end
      // Data stays on the bus one cycle past chip-select for RAM hold time
      WR: begin
        state_n = WR_END;
        cs_n    = 1'b0;
      end
      WR_END: begin
        state_n = IDLE;
        io_oe_n = 1'b0;
        wptr_n  = wptr + 3'd1;
        count_n = count + 4'd1;
      end
      RD: begin
        state_n = RD_CAP;
      end
      RD_CAP: begin
        state_n    = IDLE;
        rd_data_n  = ram_io;
        rd_valid_n = 1'b1;
        cs_n       = 1'b0;
        rptr_n     = rptr + 3'd1;
        count_n    = count - 4'd1;
      end
      default: begin
        state_n = IDLE;
        cs_n    = 1'b0;
        io_oe_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= 3'd0;
      rptr       <= 3'd0;
      count      <= 4'd0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ram_addr   <= 3'd0;
      ram_cs     <= 1'b0;
      ram_rw     <= 1'b0;
      io_oe      <= 1'b0;
    end else begin
      state      <= state_n;
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      count      <= count_n;
      wdata_q    <= wdata_n;
      rd_data_q  <= rd_data_n;
      rd_valid_q <= rd_valid_n;
      ram_addr   <= addr_n;
      ram_cs     <= cs_n;
      ram_rw     <= rw_n;
      io_oe      <= io_oe_n;
    end
  end

`ifdef FIFO_RAM_CTRL_ALMOST_EN
  logic almost_full_q, almost_empty_q;

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;

  // Derived from the next count so the flags line up with count in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_n >= 4'd7);
      almost_empty_q <= (count_n <= 4'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed self-checking bench for fifo_ram_ctrl with a behavioural 8-word RAM on ram_io.
// Define FIFO_RAM_CTRL_ALMOST_EN to also exercise almost_full/almost_empty.
module tb_fifo_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] ram_io;
  logic [2:0] ram_addr;
  logic       ram_cs;
  logic       ram_rw;
  logic [7:0] mem [8];
  int         errors = 0;
  int         checks = 0;

  fifo_ram_ctrl_if #(.N(8)) bus ();

  fifo_ram_ctrl #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .ram_io   (ram_io),
    .ram_addr (ram_addr),
    .ram_cs   (ram_cs),
    .ram_rw   (ram_rw)
  );

  always #5 clk = ~clk;

  // RAM model: writes on the rising edge, drives the bus whenever selected for read
  always @(posedge clk) begin
    if (ram_cs && ram_rw) mem[ram_addr] <= ram_io;
  end
  assign ram_io = (ram_cs && !ram_rw) ? mem[ram_addr] : 8'bz;

  always @(negedge clk) begin
    if (!rst && ram_cs && !ram_rw) begin
      checks++;
      if (dut.io_oe !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bus_contention: io_oe=%0b while RAM reads, expected 0", dut.io_oe);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_pop(output logic [7:0] d, output logic v);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
    tick();
    d = bus.rd_data;
    v = bus.rd_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (ram_cs !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_ram: cs=%0b rw=%0b addr=%0d, expected 0 0 0", ram_cs, ram_rw, ram_addr);
    end
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: count=%0d empty=%0b full=%0b, expected 0 1 0", bus.count, bus.empty, bus.full);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rd: valid=%0b data=%0h busy=%0b, expected 0 00 0", bus.rd_valid, bus.rd_data, bus.busy);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_single();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL push_ready: wr_ready=%0b, expected 1", bus.wr_ready);
    end
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (ram_addr !== 3'd0 || ram_cs !== 1'b1 || ram_rw !== 1'b1 || ram_io !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL push_wr_cycle: addr=%0d cs=%0b rw=%0b io=%0h, expected 0 1 1 a5", ram_addr, ram_cs, ram_rw, ram_io);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_busy: busy=%0b wr_ready=%0b, expected 1 0", bus.busy, bus.wr_ready);
    end
    tick();
    checks++;
    if (ram_cs !== 1'b0 || ram_io !== 8'hA5 || bus.count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL push_hold: cs=%0b io=%0h count=%0d, expected 0 a5 0", ram_cs, ram_io, bus.count);
    end
    tick();
    checks++;
    if (bus.count !== 4'd1 || bus.empty !== 1'b0 || dut.io_oe !== 1'b0 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL push_done: count=%0d empty=%0b io_oe=%0b wr_ready=%0b, expected 1 0 0 1",
               bus.count, bus.empty, dut.io_oe, bus.wr_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_cs !== 1'b0 || dut.io_oe !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: cs=%0b io_oe=%0b count=%0d empty=%0b busy=%0b, expected 0 0 0 1 0",
               ram_cs, dut.io_oe, bus.count, bus.empty, bus.busy);
    end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) do_push(8'h10 + 8'(i));
    checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_full: count=%0d full=%0b wr_ready=%0b rd_ready=%0b, expected 8 1 0 1",
               bus.count, bus.full, bus.wr_ready, bus.rd_ready);
    end
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || ram_cs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_ignore_busy: busy=%0b cs=%0b, expected 0 0", bus.busy, ram_cs);
    end
    tick();
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_ignore_count: count=%0d full=%0b, expected 8 1", bus.count, bus.full);
    end
  endtask

  task automatic test_drain();
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 8; i++) begin
      do_pop(d, v);
      checks++;
      if (v !== 1'b1 || d !== 8'h10 + 8'(i) || ram_addr !== 3'(i)) begin
        errors++;
        $display("[TB] FAIL drain_word%0d: valid=%0b data=%0h addr=%0d, expected 1 %0h %0d", i, v, d, ram_addr, 8'h10 + 8'(i), i);
      end
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h10 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL drain_pulse%0d: valid=%0b data=%0h, expected 0 %0h", i, bus.rd_valid, bus.rd_data, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.rd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty: empty=%0b count=%0d rd_ready=%0b, expected 1 0 0", bus.empty, bus.count, bus.rd_ready);
    end
    // Both pointers have travelled 7->0, so the next transfer must land on address 0
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h99;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (ram_addr !== 3'd0 || ram_rw !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_push: addr=%0d rw=%0b, expected 0 1", ram_addr, ram_rw);
    end
    tick();
    tick();
    do_pop(d, v);
    checks++;
    if (ram_addr !== 3'd0 || d !== 8'h99 || v !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_pop: addr=%0d data=%0h valid=%0b, expected 0 99 1", ram_addr, d, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       v;
    logic [7:0] exp_words [3];
    exp_words[0] = 8'h22;
    exp_words[1] = 8'h23;
    exp_words[2] = 8'h44;
    do_push(8'h21);
    do_push(8'h22);
    do_push(8'h23);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h44;
    bus.rd_en   = 1'b1;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_ready: wr_ready=%0b rd_ready=%0b, expected 0 1", bus.wr_ready, bus.rd_ready);
    end
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (ram_cs !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 3'd1) begin
      errors++;
      $display("[TB] FAIL both_pop_wins: cs=%0b rw=%0b addr=%0d, expected 1 0 1", ram_cs, ram_rw, ram_addr);
    end
    tick();
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h21 || bus.count !== 4'd2 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_pop_data: valid=%0b data=%0h count=%0d wr_ready=%0b, expected 1 21 2 1",
               bus.rd_valid, bus.rd_data, bus.count, bus.wr_ready);
    end
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (ram_rw !== 1'b1 || ram_io !== 8'h44 || ram_addr !== 3'd4) begin
      errors++;
      $display("[TB] FAIL both_push_lands: rw=%0b io=%0h addr=%0d, expected 1 44 4", ram_rw, ram_io, ram_addr);
    end
    tick();
    tick();
    checks++;
    if (bus.count !== 4'd3) begin
      errors++;
      $display("[TB] FAIL both_count: count=%0d, expected 3", bus.count);
    end
    for (int i = 0; i < 3; i++) begin
      do_pop(d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_words[i]) begin
        errors++;
        $display("[TB] FAIL both_order%0d: valid=%0b data=%0h, expected 1 %0h", i, v, d, exp_words[i]);
      end
    end
  endtask

`ifdef FIFO_RAM_CTRL_ALMOST_EN
  task automatic test_almost();
    logic [7:0] d;
    logic       v;
    checks++;
    if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL almost_idle: ae=%0b af=%0b, expected 1 0", bus.almost_empty, bus.almost_full);
    end
    for (int i = 0; i < 6; i++) do_push(8'h60 + 8'(i));
    checks++;
    if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b0 || bus.count !== 4'd6) begin
      errors++;
      $display("[TB] FAIL almost_six: af=%0b ae=%0b count=%0d, expected 0 0 6", bus.almost_full, bus.almost_empty, bus.count);
    end
    do_push(8'h66);
    checks++;
    if (bus.almost_full !== 1'b1 || bus.count !== 4'd7) begin
      errors++;
      $display("[TB] FAIL almost_full: af=%0b count=%0d, expected 1 7", bus.almost_full, bus.count);
    end
    for (int i = 0; i < 5; i++) do_pop(d, v);
    checks++;
    if (bus.almost_empty !== 1'b0 || bus.almost_full !== 1'b0 || bus.count !== 4'd2) begin
      errors++;
      $display("[TB] FAIL almost_two: ae=%0b af=%0b count=%0d, expected 0 0 2", bus.almost_empty, bus.almost_full, bus.count);
    end
    do_pop(d, v);
    checks++;
    if (bus.almost_empty !== 1'b1 || bus.count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL almost_empty: ae=%0b count=%0d, expected 1 1", bus.almost_empty, bus.count);
    end
    do_pop(d, v);
  endtask
`endif

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_push_single();
    test_async_reset();
    test_fill();
    test_drain();
    test_back_to_back();
`ifdef FIFO_RAM_CTRL_ALMOST_EN
    test_almost();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
